// File: rtl/lcb_answer_ctrl.sv
// Frame-qualified RS485 answer sequencer: A5/addr/cmd request -> turnaround -> guarded ROM byte stream to UART TX.
// One tx_start per byte, gated on tx_busy; rx input ignored while our own answer is on the line.
module lcb_answer_ctrl #(
  parameter logic [7:0] HDR       = 8'hA5,
  parameter logic [7:0] NODE_ADDR = 8'h05,
  parameter int         ANS_LEN   = 32,
  parameter int         TURN_CYC  = 80,
  parameter int         GUARD_CYC = 40,
  parameter int         GAP_CYC   = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic       dir_tx,
  output logic       dir_rx,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] req_cnt
);

  localparam int MAXC = (GAP_CYC > TURN_CYC) ? ((GAP_CYC > GUARD_CYC) ? GAP_CYC : GUARD_CYC)
                                             : ((TURN_CYC > GUARD_CYC) ? TURN_CYC : GUARD_CYC);
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [5:0]    FULL_LEN   = 6'(ANS_LEN);
  localparam logic [4:0]    STAT_ADDR  = 5'(ANS_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_CMD, S_TURN, S_PRE, S_FETCH, S_START, S_WAIT, S_POST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic [5:0]    rem_q, rem_d;
  logic [7:0]    txb_q, txb_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    req_q, req_d;
  logic          gap_hit;

  assign gap_hit = (cnt_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      txb_q   <= '0;
      ferr_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      txb_q   <= txb_d;
      ferr_q  <= ferr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    txb_d   = txb_q;
    ferr_d  = 1'b0;
    req_d   = req_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR) state_d = S_ADDR;
      end
      // A foreign node address is not an error: the frame simply isn't ours.
      S_ADDR: begin
        if (rx_valid) begin
          state_d = (rx_data == NODE_ADDR) ? S_CMD : S_IDLE;
        end else if (gap_hit) begin
          state_d = S_IDLE;
          ferr_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          if (rx_data == 8'h01) begin
            addr_d  = '0;
            rem_d   = FULL_LEN;
            req_d   = req_q + 8'd1;
            state_d = S_TURN;
          end else if (rx_data == 8'h02) begin
            addr_d  = STAT_ADDR;
            rem_d   = 6'd1;
            req_d   = req_q + 8'd1;
            state_d = S_TURN;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (gap_hit) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) state_d = S_PRE;
      end
      S_PRE: begin
        if (cnt_q == GUARD_LAST) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_START;
      S_START: begin
        txb_d   = rom_data;
        state_d = S_WAIT;
      end
      // First WAIT cycle (cnt_q==0) ignores tx_busy, which may not have risen yet.
      S_WAIT: begin
        if (cnt_q != '0 && !tx_busy) begin
          if (rem_q > 6'd1) begin
            rem_d   = rem_q - 6'd1;
            addr_d  = addr_q + 5'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (cnt_q == GUARD_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q || state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    dir_tx    = (state_q == S_PRE) || (state_q == S_FETCH) || (state_q == S_START) ||
                (state_q == S_WAIT) || (state_q == S_POST);
    dir_rx    = ~dir_tx;
    tx_start  = (state_q == S_START);
    tx_byte   = tx_start ? rom_data : txb_q;
    busy      = (state_q != S_IDLE);
    frame_err = ferr_q;
    req_cnt   = req_q;
    rom_addr  = addr_q;
  end

endmodule

// File: tb/tb_lcb_answer_ctrl.sv
// Directed bench for lcb_answer_ctrl: frame vectors table plus reset-mid-answer and gap-timeout sequences.
module tb_lcb_answer_ctrl;
  localparam int T   = 80;
  localparam int G   = 40;
  localparam int GAP = 800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy = 1'b0;
  logic       dir_tx, dir_rx, busy, frame_err;
  logic [7:0] req_cnt;

  lcb_answer_ctrl #(
    .HDR(8'hA5), .NODE_ADDR(8'h05), .ANS_LEN(32),
    .TURN_CYC(T), .GUARD_CYC(G), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .dir_tx(dir_tx), .dir_rx(dir_rx), .busy(busy),
    .frame_err(frame_err), .req_cnt(req_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_len = 0, busy_left = 0;
  int n_start, n_fe, rise_cyc, fall_cyc, first_start_cyc, fe_cyc, last_rel;
  logic prev_dir = 1'b0;
  logic [7:0] got[$];
  int exp_req = 0;

  always @(posedge clk) cyc++;
  always @(posedge clk) rom_data <= {3'b000, rom_addr};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor and transmitter model share one block so tx_busy is read before it is updated.
  always @(negedge clk) begin
    if (tx_start) begin
      check("start_while_busy", int'(tx_busy), 0);
      n_start++;
      got.push_back(tx_byte);
      if (first_start_cyc < 0) first_start_cyc = cyc;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (tx_busy && busy_left == 0) last_rel = cyc;
    tx_busy = (busy_left > 0);
    if (frame_err) begin
      n_fe++;
      fe_cyc = cyc;
    end
    if (dir_tx && !prev_dir) rise_cyc = cyc;
    if (!dir_tx && prev_dir) fall_cyc = cyc;
    prev_dir = dir_tx;
  end

  task automatic clear_mon();
    n_start = 0; n_fe = 0; rise_cyc = -1; fall_cyc = -1;
    first_start_cyc = -1; fe_cyc = -1; last_rel = -1;
    got.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output int at);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    at = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= budget) ? 1 : 0, 0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         blen;
    int         exp_n;
    logic [7:0] exp_first;
    int         exp_fe;
    int         exp_inc;
  } vec_t;

  vec_t vt[6];

  initial begin
    int t, d, bad;
    clear_mon();
    vt[0] = '{8'hA5, 8'h05, 8'h01, 4,  32, 8'h00, 0, 1};
    vt[1] = '{8'hA5, 8'h05, 8'h02, 4,  1,  8'h1F, 0, 1};
    vt[2] = '{8'hA5, 8'h07, 8'h01, 4,  0,  8'h00, 0, 0};
    vt[3] = '{8'hA5, 8'h05, 8'h33, 4,  0,  8'h00, 1, 0};
    vt[4] = '{8'h00, 8'h05, 8'h01, 4,  0,  8'h00, 0, 0};
    vt[5] = '{8'hA5, 8'h05, 8'h01, 50, 32, 8'h00, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_byte", int'(tx_byte), 0);
    check("rst_dir_tx", int'(dir_tx), 0);
    check("rst_dir_rx", int'(dir_rx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_req_cnt", int'(req_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      busy_len = vt[i].blen;
      send_byte(vt[i].b0, d);
      send_byte(vt[i].b1, d);
      send_byte(vt[i].b2, t);
      exp_req += vt[i].exp_inc;
      wait_idle(4000);
      check($sformatf("v%0d_starts", i), n_start, vt[i].exp_n);
      bad = 0;
      for (int k = 0; k < got.size() && k < vt[i].exp_n; k++)
        if (got[k] !== vt[i].exp_first + 8'(k)) bad++;
      check($sformatf("v%0d_byte_errs", i), bad, 0);
      check($sformatf("v%0d_frame_err", i), n_fe, vt[i].exp_fe);
      check($sformatf("v%0d_req_cnt", i), int'(req_cnt), exp_req & 255);
      check($sformatf("v%0d_dir_tx_end", i), int'(dir_tx), 0);
      if (vt[i].exp_n > 0) begin
        check($sformatf("v%0d_dir_rise", i), rise_cyc, t + T + 1);
        check($sformatf("v%0d_first_start", i), first_start_cyc, t + T + G + 2);
        check($sformatf("v%0d_dir_fall", i), fall_cyc, last_rel + G + 1);
        check($sformatf("v%0d_tx_byte_hold", i), int'(tx_byte),
              int'(vt[i].exp_first) + vt[i].exp_n - 1);
      end else begin
        check($sformatf("v%0d_no_dir", i), rise_cyc, -1);
      end
    end

    // Reset during byte 10, with an echoed request injected during turnaround.
    clear_mon();
    busy_len = 4;
    send_byte(8'hA5, d);
    send_byte(8'h05, d);
    send_byte(8'h01, d);
    exp_req++;
    repeat (5) @(negedge clk);
    send_byte(8'hA5, d);
    send_byte(8'h05, d);
    send_byte(8'h02, d);
    begin
      int n = 0;
      while (n_start < 10 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("rst_mid_reach_byte10", n_start, 10);
    end
    check("echo_ignored_req_cnt", int'(req_cnt), exp_req & 255);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_dir_tx", int'(dir_tx), 0);
    check("mid_rst_dir_rx", int'(dir_rx), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_req_cnt", int'(req_cnt), 0);
    rst = 1'b0;
    exp_req = 0;
    repeat (300) @(negedge clk);
    check("mid_rst_no_more_start", n_start, 10);
    check("mid_rst_dir_stays_low", int'(dir_tx), 0);

    // Gap timeout in CMD, then a normal request.
    clear_mon();
    send_byte(8'hA5, d);
    send_byte(8'h05, t);
    repeat (GAP + 10) @(negedge clk);
    check("gap_fe_count", n_fe, 1);
    check("gap_fe_cycle", fe_cyc, t + GAP + 1);
    check("gap_busy_after", int'(busy), 0);
    check("gap_req_cnt", int'(req_cnt), 0);
    clear_mon();
    busy_len = 4;
    send_byte(8'hA5, d);
    send_byte(8'h05, d);
    send_byte(8'h02, d);
    exp_req++;
    wait_idle(4000);
    check("post_gap_starts", n_start, 1);
    check("post_gap_byte", (got.size() > 0) ? int'(got[0]) : -1, 8'h1F);
    check("post_gap_req_cnt", int'(req_cnt), exp_req & 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
